fp_exp_align_pipe: RTL and testbench

- Two-stage pipelined exponent-compare and mantissa-align unit for the FPU add/sub datapath.
- Per operation:
  - compares exponents of operands A and B, with a mantissa tie-break on equal exponents;
  - selects the larger-magnitude operand;
  - right-shifts the smaller mantissa by the exponent difference, producing guard/round/sticky bits.
- Sits between operand unpack and the mantissa adder; valid/ready handshake on both sides.

---
 rtl/fpu_pkg.sv | 31 +++
 rtl/fp_sticky_shifter.sv | 28 ++
 rtl/fp_exp_align_pipe.sv | 121 ++++++++++++
 tb/tb_fp_exp_align_pipe.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU widths and the payload structs of the exponent-align pipeline.
package fpu_pkg;

  localparam int unsigned EXP_W = 8;
  localparam int unsigned MAN_W = 24;
  localparam int unsigned GRS_W = 3;
  localparam int unsigned ALN_W = MAN_W + GRS_W;

  // Stage-1 payload: operands ordered by magnitude, plus exponent distance.
  typedef struct packed {
    logic [EXP_W-1:0] big_exp;
    logic [EXP_W:0]   diff;
    logic [MAN_W-1:0] big_man;
    logic [MAN_W-1:0] small_man;
    logic             swap;
    logic             eff_sub;
    logic             sign_res;
  } align_op_t;

  // Stage-2 payload: mantissas widened with guard/round/sticky and aligned.
  typedef struct packed {
    logic [EXP_W-1:0] big_exp;
    logic [EXP_W:0]   diff;
    logic [ALN_W-1:0] big_man;
    logic [ALN_W-1:0] small_man;
    logic             swap;
    logic             eff_sub;
    logic             sign_res;
  } aligned_op_t;

endpackage

// File: rtl/fp_sticky_shifter.sv
// Combinational logical right shift that folds every shifted-out bit into the LSB.
module fp_sticky_shifter #(
  parameter int unsigned W    = 27,
  parameter int unsigned SH_W = 9
) (
  input  logic [W-1:0]    din,
  input  logic [SH_W-1:0] shamt,
  output logic [W-1:0]    dout_c
);

  logic [W-1:0] shifted;
  logic [W-1:0] lost;

  // Shift, collect lost bits, and flush to a lone sticky bit on full shift-out.
  always_comb begin
    shifted = '0;
    lost    = '0;
    dout_c  = '0;
    if (32'(shamt) >= W) begin
      dout_c = {{(W-1){1'b0}}, |din};
    end else begin
      shifted = din >> shamt;
      lost    = din & ~({W{1'b1}} << shamt);
      dout_c  = {shifted[W-1:1], shifted[0] | (|lost)};
    end
  end

endmodule

// File: rtl/fp_exp_align_pipe.sv
// Two-stage exponent compare / mantissa align front end of the FP adder.
module fp_exp_align_pipe #(
  parameter int unsigned EXP_W = fpu_pkg::EXP_W,
  parameter int unsigned MAN_W = fpu_pkg::MAN_W,
  parameter int unsigned ALN_W = MAN_W + fpu_pkg::GRS_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [EXP_W-1:0] i_exp_a,
  input  logic [EXP_W-1:0] i_exp_b,
  input  logic [MAN_W-1:0] i_man_a,
  input  logic [MAN_W-1:0] i_man_b,
  input  logic             i_sign_a,
  input  logic             i_sign_b,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [EXP_W-1:0] o_big_exp,
  output logic [EXP_W:0]   o_exp_diff,
  output logic [ALN_W-1:0] o_big_man,
  output logic [ALN_W-1:0] o_small_man,
  output logic             o_swap,
  output logic             o_sign_res,
  output logic             o_eff_sub
);

  import fpu_pkg::align_op_t;
  import fpu_pkg::aligned_op_t;
  import fpu_pkg::GRS_W;

  logic        s1_valid;
  logic        s2_valid;
  logic        s2_ready;
  logic        s1_load;
  logic        s2_load;
  align_op_t   s1_d;
  align_op_t   s1_q;
  aligned_op_t s2_d;
  aligned_op_t s2_q;

  logic [EXP_W:0]   diff_raw;
  logic [EXP_W-1:0] mag_low;
  logic             a_big;
  logic [ALN_W-1:0] small_aligned;

  // Handshake: a stage loads when its successor is empty or draining.
  assign s2_ready = !s2_valid || i_ready;
  assign o_ready  = !s1_valid || s2_ready;
  assign s1_load  = i_valid && o_ready;
  assign s2_load  = s1_valid && s2_ready;

  // Stage 1: subtract exponents, pick the larger magnitude, take |diff|.
  always_comb begin
    diff_raw = {1'b0, i_exp_a} + {1'b0, ~i_exp_b} + (EXP_W+1)'(1);
    a_big    = diff_raw[EXP_W] && ((i_exp_a != i_exp_b) || (i_man_a >= i_man_b));
    mag_low  = a_big ? diff_raw[EXP_W-1:0] : EXP_W'(~diff_raw[EXP_W-1:0] + EXP_W'(1));
    s1_d           = '0;
    s1_d.swap      = !a_big;
    s1_d.big_exp   = a_big ? i_exp_a : i_exp_b;
    s1_d.big_man   = a_big ? i_man_a : i_man_b;
    s1_d.small_man = a_big ? i_man_b : i_man_a;
    s1_d.diff      = {1'b0, mag_low};
    s1_d.eff_sub   = i_sign_a ^ i_sign_b ^ i_sub;
    s1_d.sign_res  = a_big ? i_sign_a : (i_sign_b ^ i_sub);
  end

  // Stage 1 register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else begin
      if (o_ready) s1_valid <= i_valid;
      if (s1_load) s1_q <= s1_d;
    end
  end

  fp_sticky_shifter #(
    .W    (ALN_W),
    .SH_W (EXP_W + 1)
  ) u_align_shift (
    .din    ({s1_q.small_man, GRS_W'(0)}),
    .shamt  (s1_q.diff),
    .dout_c (small_aligned)
  );

  // Stage 2: widen both mantissas with GRS and attach the aligned small one.
  always_comb begin
    s2_d           = '0;
    s2_d.big_exp   = s1_q.big_exp;
    s2_d.diff      = s1_q.diff;
    s2_d.big_man   = {s1_q.big_man, GRS_W'(0)};
    s2_d.small_man = small_aligned;
    s2_d.swap      = s1_q.swap;
    s2_d.eff_sub   = s1_q.eff_sub;
    s2_d.sign_res  = s1_q.sign_res;
  end

  // Stage 2 register; holds while downstream stalls.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s2_valid <= 1'b0;
      s2_q     <= '0;
    end else begin
      if (s2_ready) s2_valid <= s1_valid;
      if (s2_load) s2_q <= s2_d;
    end
  end

  assign o_valid     = s2_valid;
  assign o_big_exp   = s2_q.big_exp;
  assign o_exp_diff  = s2_q.diff;
  assign o_big_man   = s2_q.big_man;
  assign o_small_man = s2_q.small_man;
  assign o_swap      = s2_q.swap;
  assign o_sign_res  = s2_q.sign_res;
  assign o_eff_sub   = s2_q.eff_sub;

endmodule

// File: tb/tb_fp_exp_align_pipe.sv
// Directed bench for the exponent-align pipeline.
module tb_fp_exp_align_pipe;

  localparam int unsigned EXP_W = 8;
  localparam int unsigned MAN_W = 24;
  localparam int unsigned ALN_W = 27;

  logic             i_clk = 1'b0;
  logic             i_rst_n = 1'b0;
  logic             i_valid = 1'b0;
  logic             o_ready;
  logic [EXP_W-1:0] i_exp_a = '0;
  logic [EXP_W-1:0] i_exp_b = '0;
  logic [MAN_W-1:0] i_man_a = '0;
  logic [MAN_W-1:0] i_man_b = '0;
  logic             i_sign_a = 1'b0;
  logic             i_sign_b = 1'b0;
  logic             i_sub = 1'b0;
  logic             o_valid;
  logic             i_ready = 1'b1;
  logic [EXP_W-1:0] o_big_exp;
  logic [EXP_W:0]   o_exp_diff;
  logic [ALN_W-1:0] o_big_man;
  logic [ALN_W-1:0] o_small_man;
  logic             o_swap;
  logic             o_sign_res;
  logic             o_eff_sub;

  int checks = 0;
  int errors = 0;

  fp_exp_align_pipe dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_exp_a     (i_exp_a),
    .i_exp_b     (i_exp_b),
    .i_man_a     (i_man_a),
    .i_man_b     (i_man_b),
    .i_sign_a    (i_sign_a),
    .i_sign_b    (i_sign_b),
    .i_sub       (i_sub),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_big_exp   (o_big_exp),
    .o_exp_diff  (o_exp_diff),
    .o_big_man   (o_big_man),
    .o_small_man (o_small_man),
    .o_swap      (o_swap),
    .o_sign_res  (o_sign_res),
    .o_eff_sub   (o_eff_sub)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [63:0] be, input logic [63:0] d,
                           input logic [63:0] bm, input logic [63:0] sm, input logic [63:0] sw,
                           input logic [63:0] sr, input logic [63:0] es);
    chk({tag, ".valid"},    64'(o_valid),     64'd1);
    chk({tag, ".big_exp"},  64'(o_big_exp),   be);
    chk({tag, ".diff"},     64'(o_exp_diff),  d);
    chk({tag, ".big_man"},  64'(o_big_man),   bm);
    chk({tag, ".small_man"},64'(o_small_man), sm);
    chk({tag, ".swap"},     64'(o_swap),      sw);
    chk({tag, ".sign_res"}, 64'(o_sign_res),  sr);
    chk({tag, ".eff_sub"},  64'(o_eff_sub),   es);
  endtask

  task automatic drive(input logic [7:0] ea, input logic [7:0] eb, input logic [23:0] ma,
                       input logic [23:0] mb, input logic sa, input logic sb, input logic sub);
    i_valid  = 1'b1;
    i_exp_a  = ea;
    i_exp_b  = eb;
    i_man_a  = ma;
    i_man_b  = mb;
    i_sign_a = sa;
    i_sign_b = sb;
    i_sub    = sub;
  endtask

  // One op through an empty pipe: accepted at once, not visible after 1 edge, visible after 2.
  task automatic single(input string tag, input logic [7:0] ea, input logic [7:0] eb,
                        input logic [23:0] ma, input logic [23:0] mb, input logic sa,
                        input logic sb, input logic sub, input logic [63:0] be,
                        input logic [63:0] d, input logic [63:0] bm, input logic [63:0] sm,
                        input logic [63:0] sw, input logic [63:0] sr, input logic [63:0] es);
    @(negedge i_clk);
    drive(ea, eb, ma, mb, sa, sb, sub);
    chk({tag, ".ready"}, 64'(o_ready), 64'd1);
    @(negedge i_clk);
    i_valid = 1'b0;
    chk({tag, ".lat1"}, 64'(o_valid), 64'd0);
    @(negedge i_clk);
    check_out(tag, be, d, bm, sm, sw, sr, es);
  endtask

  initial begin
    // Reset state
    #3;
    chk("rst.valid", 64'(o_valid), 64'd0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    #1;
    chk("rst.ready",   64'(o_ready),     64'd1);
    chk("rst.big_exp", 64'(o_big_exp),   64'd0);
    chk("rst.small",   64'(o_small_man), 64'd0);

    // A larger by exponent, diff 3, no bits lost
    single("t1", 8'h85, 8'h82, 24'hC00000, 24'h800000, 1'b0, 1'b0, 1'b0,
           'h85, 3, 'h6000000, 'h0800000, 0, 0, 0);
    // Equal exponents, mantissa tie-break picks B
    single("t2", 8'h80, 8'h80, 24'hA00000, 24'hB00000, 1'b0, 1'b0, 1'b1,
           'h80, 0, 'h5800000, 'h5000000, 1, 1, 1);
    // Huge diff: full flush to sticky
    single("t3", 8'h01, 8'hFE, 24'h800001, 24'hC00000, 1'b1, 1'b0, 1'b0,
           'hFE, 'hFD, 'h6000000, 1, 1, 0, 1);
    // diff 26: every bit except MSB shifted out, sticky set
    single("t4", 8'h9A, 8'h80, 24'h800000, 24'hFFFFFF, 1'b0, 1'b0, 1'b0,
           'h9A, 26, 'h4000000, 1, 0, 0, 0);
    // diff 2: guard=1 round=1 sticky=0
    single("t5", 8'h80, 8'h82, 24'h800003, 24'h900000, 1'b1, 1'b1, 1'b0,
           'h82, 2, 'h4800000, 'h1000006, 1, 1, 0);
    // Identical magnitudes with effective subtraction keep A and sign_a
    single("t6", 8'h7F, 8'h7F, 24'hABCDEF, 24'hABCDEF, 1'b1, 1'b0, 1'b0,
           'h7F, 0, 'h55E6F78, 'h55E6F78, 0, 1, 1);
    // exp_a=0, exp_b=max
    single("t7", 8'h00, 8'hFF, 24'h400000, 24'h800000, 1'b0, 1'b0, 1'b0,
           'hFF, 'hFF, 'h4000000, 1, 1, 0, 0);
    // Zero mantissa as smaller operand
    single("t8", 8'h90, 8'h88, 24'h800000, 24'h000000, 1'b0, 1'b0, 1'b0,
           'h90, 8, 'h4000000, 0, 0, 0, 0);

    // Stall: downstream blocked for 3 cycles while 4 ops stream in
    @(negedge i_clk);
    i_ready = 1'b0;
    drive(8'h10, 8'h10, 24'h800000, 24'h800000, 1'b0, 1'b0, 1'b0);
    chk("st.ready0", 64'(o_ready), 64'd1);
    @(negedge i_clk);
    drive(8'h11, 8'h10, 24'h800000, 24'h800000, 1'b0, 1'b0, 1'b0);
    chk("st.ready1", 64'(o_ready), 64'd1);
    @(negedge i_clk);
    drive(8'h12, 8'h10, 24'h800000, 24'h800000, 1'b0, 1'b0, 1'b0);
    chk("st.ready2", 64'(o_ready), 64'd0);
    check_out("st.op0a", 'h10, 0, 'h4000000, 'h4000000, 0, 0, 0);
    @(negedge i_clk);
    chk("st.ready3", 64'(o_ready), 64'd0);
    check_out("st.op0b", 'h10, 0, 'h4000000, 'h4000000, 0, 0, 0);
    i_ready = 1'b1;
    @(negedge i_clk);
    check_out("st.op1", 'h11, 1, 'h4000000, 'h2000000, 0, 0, 0);
    drive(8'h13, 8'h10, 24'h800000, 24'h800000, 1'b0, 1'b0, 1'b0);
    chk("st.ready4", 64'(o_ready), 64'd1);
    @(negedge i_clk);
    i_valid = 1'b0;
    check_out("st.op2", 'h12, 2, 'h4000000, 'h1000000, 0, 0, 0);
    @(negedge i_clk);
    check_out("st.op3", 'h13, 3, 'h4000000, 'h0800000, 0, 0, 0);
    @(negedge i_clk);
    chk("st.empty", 64'(o_valid), 64'd0);

    // Reset with both stages full
    i_ready = 1'b0;
    drive(8'h20, 8'h10, 24'h800000, 24'h800000, 1'b0, 1'b0, 1'b0);
    @(negedge i_clk);
    drive(8'h21, 8'h10, 24'h800000, 24'h800000, 1'b0, 1'b0, 1'b0);
    @(negedge i_clk);
    i_valid = 1'b0;
    chk("mr.full_valid", 64'(o_valid), 64'd1);
    chk("mr.full_ready", 64'(o_ready), 64'd0);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("mr.valid",     64'(o_valid),     64'd0);
    chk("mr.big_exp",   64'(o_big_exp),   64'd0);
    chk("mr.diff",      64'(o_exp_diff),  64'd0);
    chk("mr.big_man",   64'(o_big_man),   64'd0);
    chk("mr.small_man", 64'(o_small_man), 64'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_ready = 1'b1;
    single("mr.after", 8'h85, 8'h82, 24'hC00000, 24'h800000, 1'b0, 1'b0, 1'b0,
           'h85, 3, 'h6000000, 'h0800000, 0, 0, 0);
    @(negedge i_clk);
    chk("mr.drained", 64'(o_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
